// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and constants for the UART TX arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARB     = 2'd1,
        S_SEND    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Transmitter state codes as seen on tx_state.
    localparam logic [4:0] TX_IDLE_STATE     = 5'h00;
    localparam logic [4:0] DEF_TX_DONE_STATE = 5'h10;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    input  logic [2:0]   ptr_i,
    output logic [N-1:0] grant_o,
    output logic [2:0]   idx_o,
    output logic         valid_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;
    int             off;
    int             pos;

    // Rotate requests so bit 0 is the slot after the pointer, then take the lowest set bit.
    always_comb begin
        dbl     = {req_i, req_i};
        shifted = dbl >> (int'(ptr_i) + 1);
        rot     = shifted[N-1:0];
        off     = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = j;
            end
        end
        pos     = (int'(ptr_i) + 1 + off) % N;
        idx_o   = 3'(pos);
        valid_o = |req_i;
        grant_o = valid_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin share of one UART transmitter; optional watchdog via UART_ARB_TIMEOUT_EN
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_REQ        = 4,
    parameter logic [4:0] TX_DONE_STATE  = DEF_TX_DONE_STATE,
    parameter int         TIMEOUT_CYCLES = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic [4:0]           tx_state,
    output logic                 tx_timeout
);

    localparam logic [2:0] PTR_RST = 3'(NUM_REQ - 1);

    state_t             state_q;
    logic [2:0]         ptr_q;
    logic [2:0]         grant_q;
    logic [NUM_REQ-1:0] gnt_oh_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               start_q;
    logic               busy_q;
    logic [7:0]         data_q;

    logic [NUM_REQ-1:0] pick_oh;
    logic [2:0]         pick_idx;
    logic               pick_valid;
    logic               tx_done;
    logic               expired;

    assign tx_done = (tx_state == TX_DONE_STATE);

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (pick_oh),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

`ifdef UART_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;

    assign cnt_d   = cnt_q + CNT_W'(1);
    // The edge that would bring the count to TIMEOUT_CYCLES aborts the frame.
    assign expired = (cnt_q == CNT_LAST);

    // Watchdog: cleared while arbitrating, counts every SEND cycle, flags the abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == S_ARB) begin
                cnt_q <= '0;
            end else if (state_q == S_SEND) begin
                cnt_q <= cnt_d;
            end
            timeout_q <= (state_q == S_SEND) && !tx_done && expired;
        end
    end

    assign tx_timeout = timeout_q;
`else
    assign expired    = 1'b0;
    assign tx_timeout = 1'b0;
`endif

    // Arbitration FSM; every output comes straight from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= PTR_RST;
            grant_q  <= '0;
            gnt_oh_q <= '0;
            ack_q    <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            ack_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    start_q <= 1'b0;
                    if (|req) begin
                        state_q <= S_ARB;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (pick_valid) begin
                        grant_q  <= pick_idx;
                        gnt_oh_q <= pick_oh;
                        data_q   <= req_data[{pick_idx, 3'b000} +: 8];
                        start_q  <= 1'b1;
                        state_q  <= S_SEND;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (tx_done || expired) begin
                        start_q <= 1'b0;
                        ack_q   <= gnt_oh_q;
                        ptr_q   <= grant_q;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign tx_start = start_q;
    assign tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int         N    = 4;
    localparam logic [4:0] DONE = 5'h10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] req_data = '0;
    logic [4:0]     tx_state = 5'h00;
    logic [N-1:0]   ack;
    logic [2:0]     grant_id;
    logic           busy;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TX_DONE_STATE  (DONE),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .grant_id   (grant_id),
        .busy       (busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_state   (tx_state),
        .tx_timeout (tx_timeout)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] b;
        bit         to;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] frames[$];
    int         nframes = 0;
    bit         stuck   = 1'b0;
    int         rearm   = 0;
    logic [7:0] cap;

    task automatic push_exp(input int idx, input logic [7:0] b, input bit to);
        exp_t e;
        e.idx = idx;
        e.b   = b;
        e.to  = to;
        expq.push_back(e);
    endtask

    // Transmitter model: latches tx_data at start, walks 1..DONE, aborts when start drops early.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst || !tx_start) begin
            tx_state = 5'h00;
        end else if (stuck) begin
            tx_state = 5'h01;
        end else if (tx_state == 5'h00) begin
            cap      = tx_data;
            tx_state = 5'h01;
        end else if (tx_state != DONE) begin
            tx_state = tx_state + 5'h01;
            if (tx_state == DONE) begin
                frames.push_back(cap);
                nframes++;
            end
        end
    end

    // Requesters drop req on the edge that ends their ack; optionally re-request.
    initial begin : requesters
        logic [N-1:0] a;
        forever begin
            @(negedge clk);
            if (!rst && ack != '0) begin
                a = ack;
                @(posedge clk);
                #1;
                req = req & ~a;
                if (rearm > 0) begin
                    req = req | a;
                    rearm--;
                end
            end
        end
    end

    // Monitor: every ack is matched against the next scoreboard entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && ack != '0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    e = expq.pop_front();
                    chk("ack_vec", 32'(ack), 32'(1 << e.idx));
                    chk("grant_id", 32'(grant_id), 32'(e.idx));
                    chk("tx_timeout", 32'(tx_timeout), 32'(e.to));
                    chk("frames_pending", 32'(frames.size()), e.to ? 32'd0 : 32'd1);
                    if (frames.size() > 0) begin
                        chk("frame_byte", 32'(frames.pop_front()), 32'(e.b));
                    end
                end
                chk("tx_start_low_in_ack", 32'(tx_start), 32'h0);
                @(negedge clk);
                chk("ack_one_cycle", 32'(ack), 32'h0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        expq.delete();
        frames.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while ((expq.size() != 0 || busy || req != '0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_in_budget", 32'(c < budget), 32'h1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_state(input logic [4:0] s, input string nm);
        int c = 0;
        while (tx_state != s && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 32'(tx_state), 32'(s));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n0;
        int c;

        // Reset values.
        @(negedge clk);
        chk("reset_outputs", {13'h0, tx_start, busy, tx_timeout, ack, grant_id, tx_data}, 32'h0);

        // 1: single requester 2, byte 0x55.
        do_reset();
        n0 = nframes;
        req_data[23:16] = 8'h55;
        req = 4'b0100;
        push_exp(2, 8'h55, 1'b0);
        @(posedge clk); #1;
        chk("t1_start_after1", 32'(tx_start), 32'h0);
        chk("t1_busy_arb", 32'(busy), 32'h1);
        @(posedge clk); #1;
        chk("t1_start_after2", 32'(tx_start), 32'h1);
        chk("t1_grant", 32'(grant_id), 32'h2);
        chk("t1_tx_data", 32'(tx_data), 32'h55);
        wait_state(DONE, "t1_done_reached");
        chk("t1_start_held", 32'(tx_start), 32'h1);
        @(posedge clk); #1;
        chk("t1_start_drop", 32'(tx_start), 32'h0);
        chk("t1_ack", 32'(ack), 32'h4);
        wait_done(200);
        chk("t1_one_frame", 32'(nframes - n0), 32'h1);

        // 2: all four at once after reset -> 0,1,2,3.
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req = 4'b1111;
        for (int i = 0; i < N; i++) push_exp(i, 8'hA0 + 8'(i), 1'b0);
        wait_done(400);

        // 3: requesters 0 and 3 keep coming back -> 0,3,0,3.
        do_reset();
        req_data = {8'h33, 8'h00, 8'h00, 8'h30};
        rearm = 2;
        req = 4'b1001;
        push_exp(0, 8'h30, 1'b0);
        push_exp(3, 8'h33, 1'b0);
        push_exp(0, 8'h30, 1'b0);
        push_exp(3, 8'h33, 1'b0);
        wait_done(400);

        // 4: req_data changes mid-frame; the latched byte goes out.
        req_data = '0;
        req_data[15:8] = 8'h11;
        req = 4'b0010;
        push_exp(1, 8'h11, 1'b0);
        wait_state(5'h05, "t4_mid_frame");
        req_data[15:8] = 8'hEE;
        @(negedge clk);
        chk("t4_tx_data_frozen", 32'(tx_data), 32'h11);
        wait_done(200);

        // 5: reset in the middle of a frame, then normal service from requester 0.
        req_data = '0;
        req_data[23:16] = 8'h77;
        req = 4'b0100;
        n0 = nframes;
        wait_state(5'h0A, "t5_mid_frame");
        rst = 1'b1;
        #1;
        chk("t5_start_async", 32'(tx_start), 32'h0);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_ack", 32'(ack), 32'h0);
        req = '0;
        repeat (2) @(negedge clk);
        chk("t5_no_frame", 32'(nframes - n0), 32'h0);
        chk("t5_line_idle", 32'(tx_state), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        req_data = {8'h00, 8'h00, 8'h5B, 8'h5A};
        req = 4'b0011;
        push_exp(0, 8'h5A, 1'b0);
        push_exp(1, 8'h5B, 1'b0);
        wait_done(400);

`ifdef UART_ARB_TIMEOUT_EN
        // 6: stuck transmitter -> watchdog abort after 50 SEND cycles, then next requester.
        do_reset();
        stuck = 1'b1;
        req_data = {8'h00, 8'h00, 8'h61, 8'h60};
        req = 4'b0011;
        push_exp(0, 8'h60, 1'b1);
        push_exp(1, 8'h61, 1'b0);
        c = 0;
        while (!tx_start && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("t6_started", 32'(tx_start), 32'h1);
        c = 0;
        while (!tx_timeout && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk("t6_timeout_cycle", 32'(c), 32'd50);
        stuck = 1'b0;
        wait_done(400);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one async_transmit-style RS-232 transmitter among NUM_REQ requesters.
- Arbitration is round-robin. The block latches the winner's byte and sequences the transmitter's start handshake: start is held high for the whole frame, then dropped at the done state.
- It returns a one-cycle ack to the requester that was served.
- Sits between the debug/status producers and the single TX pin driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TX_DONE_STATE, 5'h10, transmitter state code meaning "stop bits sent, waiting for start to drop".
- TIMEOUT_CYCLES, 2000, maximum clocks allowed in SEND (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester send request; held until acked.
- req_data  in  NUM_REQ*8  byte for requester i at bits [8i+7:8i]; held stable while req[i] is high.
- ack  out  NUM_REQ  one-cycle pulse when requester's byte has been fully transmitted.
- grant_id  out  3  index of the requester currently owning the transmitter.
- busy  out  1  high in ARB, SEND and RELEASE.
- tx_start  out  1  to transmitter start input.
- tx_data  out  8  to transmitter data input (registered).
- tx_state  in  5  transmitter state vector.
- tx_timeout  out  1  one-cycle pulse on watchdog abort (always 0 without the feature).

Behaviour:
- Reset (asynchronous) values:
  - FSM=IDLE.
  - tx_start=0, tx_data=0, ack=0, grant_id=0, busy=0, tx_timeout=0.
  - RR pointer=NUM_REQ-1, so requester 0 has top priority after reset.
- FSM, all outputs registered:
  - IDLE: tx_start=0. If |req, go to ARB.
  - ARB (1 cycle): pick the first set req[i] searching from pointer+1, modulo NUM_REQ. Register grant_id=i and tx_data=req_data[i]. If no req remains, go back to IDLE; otherwise go to SEND.
  - SEND: tx_start=1 and held. When tx_state==TX_DONE_STATE, go to RELEASE.
  - RELEASE (1 cycle): tx_start=0, which returns the transmitter to state 0. ack[grant_id]=1, pointer=grant_id. Then go to IDLE.
- Latency: req rising while in IDLE gives tx_start high 2 clocks later.
- tx_start is low for at least 3 consecutive cycles between frames (RELEASE, IDLE, ARB).
- Requester rule: it must clear req on the clock edge that ends its ack cycle. The arbiter never re-grants the same index back-to-back while another req is pending.
- tx_data is frozen for the whole of SEND; changes on req_data in that window have no effect.
- req dropped by its owner during SEND: ignored. The frame completes and the ack is still issued.
- Simultaneous requests: strict rotation. Each requester waits at most NUM_REQ-1 frames.
- Reset mid-SEND: tx_start falls immediately. The transmitter aborts at its next clock, the line idles high and no ack is issued. The bench accepts one truncated frame.
- Counters and compares are unsigned. The pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to SEND and increments each SEND cycle.
  - If it reaches TIMEOUT_CYCLES before TX_DONE_STATE, go to RELEASE.
  - In that RELEASE: tx_start=0, tx_timeout=1, ack[grant_id]=1, and the pointer advances, so a stuck transmitter cannot deadlock the requesters.
- Undefined: no counter is built, tx_timeout is tied 0, and SEND waits indefinitely.

Decomposition:
- Package uart_arb_pkg:
  - state enum: IDLE, ARB, SEND, RELEASE.
  - TX_IDLE_STATE=5'h00.
  - default TX_DONE_STATE=5'h10.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, pointer.
  - Outputs: onehot grant, encoded index, valid.
- Instantiated once in ARB.

Test Plan:
1. NUM_REQ=4, req=4'b0100, byte 0x55:
   - grant_id=2, tx_data=0x55, tx_start high 2 clocks after req.
   - tx_start held through the frame, then drops the cycle after tx_state==0x10.
   - ack=4'b0100 for exactly 1 cycle; exactly one frame on the TX line.
2. After reset, req=4'b1111 with bytes 0xA0..0xA3: frames come out in order 0xA0, 0xA1, 0xA2, 0xA3, with acks 0,1,2,3.
3. req[0] re-asserted immediately after each ack, req[3] held: grants alternate 0,3,0,3, and req[3] is never starved.
4. req_data[1] changes from 0x11 to 0xEE mid-SEND: tx_data stays 0x11 and the transmitted byte is 0x11.
5. rst pulsed while tx_state=0x0A:
   - tx_start=0 immediately, FSM=IDLE, no ack.
   - The next request is served normally from requester 0.
6. With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50, tx_state stuck at 5'h01:
   - tx_timeout and ack pulse at SEND cycle 50.
   - The next pending requester is granted.
